plab5_mcore_mem_req_cmsg_unpack_queue: RTL and testbench
========================================================

Name: plab5_mcore_mem_req_cmsg_unpack_queue

Overview:
Parametrised buffered unpacker for memory-request control messages (data field already stripped) on the path from core/cache into the memory network. Holds up to p_num_entries messages in a val/rdy FIFO, each tagged with its NS security-domain bit. Presents the head entry as unpacked fields, plus two derived fields: byte count and misalignment flag. One clock, no bypass.

Parameters:
p_opaque_nbits, 8, opaque field width (o)
p_addr_nbits, 32, address field width (a)
p_data_nbits, 32, data width (d); multiple of 8, power of 2
p_num_entries, 2, FIFO depth; power of 2, >= 2
p_chk_align, 1, 1 = compute out_misaligned; 0 = tie it to 0

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
in_val  in  1  input message valid
in_rdy  out  1  queue can accept
in_msg  in  c  packed control message {type, opaque, addr, len}; c = T+o+a+l, where T = `VC_MEM_REQ_MSG_TYPE_NBITS and l = `VC_MEM_REQ_MSG_LEN_NBITS
in_ns  in  1  security domain of message (1 = non-secure)
out_val  out  1  head entry valid
out_rdy  in  1  consumer accepts head
out_type  out  T  head type field
out_opaque  out  o  head opaque field
out_addr  out  a  head address
out_len  out  l  head raw len field
out_nbytes  out  l+1  byte count: len==0 -> d/8, else len
out_ns  out  1  head domain bit
out_misaligned  out  1  addr not aligned to out_nbytes
count  out  clog2(p_num_entries)+1  current occupancy

Behaviour:
- Reset (reset_n low, asynchronous): head ptr, tail ptr and count go to 0. in_rdy=0 while reset_n is low, and 1 from the first cycle after release. out_val=0, count=0. Storage contents are don't-care; all out_* fields must still be driven deterministically from the head storage slot.
- Enqueue: on a rising edge with in_val & in_rdy, write {in_msg, in_ns} at tail; tail = (tail+1) mod p_num_entries, wrapping naturally via power-of-2 width.
- Dequeue: on a rising edge with out_val & out_rdy, head = (head+1) mod p_num_entries.
- in_rdy = (count != p_num_entries). A full queue does not accept, even if a dequeue happens in the same cycle (no pipe-through).
- out_val = (count != 0). An empty queue does not bypass, so latency is exactly 1 cycle from enqueue to out_val.
- Simultaneous enqueue and dequeue when 0 < count < full: count unchanged, both pointers advance.
- Field split of the head message: type = msg[c-1 : l+a+o], opaque = msg[l+a+o-1 : l+a], addr = msg[l+a-1 : l], len = msg[l-1 : 0]. All outputs are combinational from the head slot.
- out_nbytes is one bit wider than len so that it can represent d/8.
- out_misaligned = p_chk_align & |(addr & (out_nbytes-1)) when out_nbytes is a power of 2. For non-power-of-2 nbytes (e.g. 3), out_misaligned = p_chk_align & |(addr[l-1:0]).
- The block only flags misalignment; it never drops or alters a message.
- out_* values are don't-care while out_val=0, but must not be X after reset.
- reset_n asserted mid-transfer: all entries are discarded immediately, with no partial handshake completing on that edge.
- NS bit travels atomically with its message. The block performs no cross-entry mixing of fields.

Decomposition:
- Shared package/header: T, l and c width macros, MEM_REQ type encodings (READ=0, WRITE=1, INIT=2), and an nbytes helper macro.
- Natural sub-module: plab5_mcore_mem_req_cmsg_field_split. It is purely combinational and performs the slicing, nbytes and misalignment computation. Instantiate it once on the head slot.
- The FIFO core (pointers, count, storage array) stays in the top module.

Test Plan:
- Reset, then enqueue {type=0, opaque=0x05, addr=0x1000, len=0}, ns=1 -> the next cycle gives out_val=1, nbytes=4, misaligned=0, ns=1, count=1.
- Hold out_rdy=0 and enqueue 3 messages with depth 2 -> in_rdy=0 after 2 enqueues, count=2, third message held at the producer.
- Full queue, then assert in_val and out_rdy in the same cycle -> only the dequeue occurs, count=1, and the enqueue completes on the next cycle.
- Stream 6 messages with out_rdy=1 and in_val=1 continuously -> throughput of 1/cycle after the first, order preserved across pointer wrap, and ns bits match per message.
- Enqueue {type=1, addr=0x1002, len=0} -> misaligned=1. Enqueue {addr=0x1002, len=2} -> misaligned=0. Repeat with p_chk_align=0 -> misaligned=0 in both cases.
- With count=2, pull reset_n low mid-cycle -> out_val and count drop to 0 immediately without waiting for a clock edge, and in_rdy=1 on the first clock after release.

Source files
------------

// File: rtl/plab5_mcore_mem_req_cmsg_unpack_queue_pkg.sv
// Shared widths, message type encodings and width helpers for the
// memory-request control-message unpack queue.
package plab5_mcore_mem_req_cmsg_unpack_queue_pkg;

  localparam int mem_req_type_nbits = 3;

  typedef enum logic [mem_req_type_nbits-1:0] {
    mem_req_read  = 3'd0,
    mem_req_write = 3'd1,
    mem_req_init  = 3'd2
  } mem_req_type_e;

  // len encodes 1..d/8-1 directly and d/8 as zero, so it needs clog2(d/8) bits
  function automatic int calc_len_nbits(input int data_nbits);
    int r;
    r = $clog2(data_nbits / 8);
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int calc_msg_nbits(input int opaque_nbits, input int addr_nbits,
                                        input int data_nbits);
    return mem_req_type_nbits + opaque_nbits + addr_nbits + calc_len_nbits(data_nbits);
  endfunction

  function automatic int calc_cnt_nbits(input int num_entries);
    return $clog2(num_entries) + 1;
  endfunction

  function automatic int calc_word_nbytes(input int data_nbits);
    return data_nbits / 8;
  endfunction

endpackage

// File: rtl/plab5_mcore_mem_req_cmsg_unpack_queue_if.sv
// Producer/consumer bundle of the unpack queue: packed messages in,
// unpacked head fields out.
interface plab5_mcore_mem_req_cmsg_unpack_queue_if
  import plab5_mcore_mem_req_cmsg_unpack_queue_pkg::*;
#(
  parameter int p_opaque_nbits = 8,
  parameter int p_addr_nbits   = 32,
  parameter int p_data_nbits   = 32
);

  localparam int len_nbits = calc_len_nbits(p_data_nbits);
  localparam int msg_nbits = calc_msg_nbits(p_opaque_nbits, p_addr_nbits, p_data_nbits);

  // Both channels are val/rdy: a transfer happens on a rising edge where val
  // and rdy are both high; val never depends on rdy, and neither rdy depends
  // on the opposite channel's val/rdy in the same cycle.
  logic                          in_val;
  logic                          in_rdy;
  logic [msg_nbits-1:0]          in_msg;
  logic                          in_ns;

  logic                          out_val;
  logic                          out_rdy;
  logic [mem_req_type_nbits-1:0] out_type;
  logic [p_opaque_nbits-1:0]     out_opaque;
  logic [p_addr_nbits-1:0]       out_addr;
  logic [len_nbits-1:0]          out_len;
  logic [len_nbits:0]            out_nbytes;
  logic                          out_ns;
  logic                          out_misaligned;

  modport master (
    output in_val, in_msg, in_ns, out_rdy,
    input  in_rdy, out_val, out_type, out_opaque, out_addr, out_len,
           out_nbytes, out_ns, out_misaligned
  );

  modport slave (
    input  in_val, in_msg, in_ns, out_rdy,
    output in_rdy, out_val, out_type, out_opaque, out_addr, out_len,
           out_nbytes, out_ns, out_misaligned
  );

endinterface

// File: rtl/plab5_mcore_mem_req_cmsg_field_split.sv
// Combinational split of one packed control message into its fields, plus the
// derived byte count and address-misalignment flag.
module plab5_mcore_mem_req_cmsg_field_split
  import plab5_mcore_mem_req_cmsg_unpack_queue_pkg::*;
#(
  parameter int p_opaque_nbits = 8,
  parameter int p_addr_nbits   = 32,
  parameter int p_data_nbits   = 32,
  parameter int p_chk_align    = 1,
  localparam int len_nbits = calc_len_nbits(p_data_nbits),
  localparam int msg_nbits = calc_msg_nbits(p_opaque_nbits, p_addr_nbits, p_data_nbits)
)(
  input  logic [msg_nbits-1:0]          msg,
  output logic [mem_req_type_nbits-1:0] msg_type,
  output logic [p_opaque_nbits-1:0]     opaque,
  output logic [p_addr_nbits-1:0]       addr,
  output logic [len_nbits-1:0]          len,
  output logic [len_nbits:0]            nbytes,
  output logic                          misaligned
);

  localparam int                 word_nbytes = calc_word_nbytes(p_data_nbits);
  localparam logic [len_nbits:0] nbytes_word = word_nbytes[len_nbits:0];
  localparam logic [len_nbits:0] nbytes_one  = {{len_nbits{1'b0}}, 1'b1};

  logic [len_nbits:0] nbytes_mask;
  logic               nbytes_pow2;
  logic               mis_pow2;
  logic               mis_other;

  assign {msg_type, opaque, addr, len} = msg;

  // A zero len means a full data word.
  assign nbytes = (len == '0) ? nbytes_word : {1'b0, len};

  assign nbytes_mask = nbytes - nbytes_one;
  assign nbytes_pow2 = ((nbytes & nbytes_mask) == '0);

  // Odd sizes such as 3 have no natural alignment; they must start word-aligned.
  assign mis_pow2  = |(addr[len_nbits:0] & nbytes_mask);
  assign mis_other = |addr[len_nbits-1:0];

  assign misaligned = (p_chk_align != 0) && (nbytes_pow2 ? mis_pow2 : mis_other);

endmodule

// File: rtl/plab5_mcore_mem_req_cmsg_unpack_queue.sv
// Buffered val/rdy queue of memory-request control messages with NS tags,
// presenting the head entry as unpacked fields. No bypass, no pipe-through.
module plab5_mcore_mem_req_cmsg_unpack_queue
  import plab5_mcore_mem_req_cmsg_unpack_queue_pkg::*;
#(
  parameter int p_opaque_nbits = 8,
  parameter int p_addr_nbits   = 32,
  parameter int p_data_nbits   = 32,
  parameter int p_num_entries  = 2,
  parameter int p_chk_align    = 1,
  localparam int msg_nbits = calc_msg_nbits(p_opaque_nbits, p_addr_nbits, p_data_nbits),
  localparam int cnt_nbits = calc_cnt_nbits(p_num_entries)
)(
  input  logic                 clk,
  input  logic                 reset_n,
  plab5_mcore_mem_req_cmsg_unpack_queue_if.slave q,
  output logic [cnt_nbits-1:0] count
);

  localparam int                 ptr_nbits = $clog2(p_num_entries);
  localparam logic [cnt_nbits-1:0] cnt_full = p_num_entries[cnt_nbits-1:0];
  localparam logic [ptr_nbits-1:0] ptr_one  = {{(ptr_nbits-1){1'b0}}, 1'b1};

  // Each slot holds {msg, ns} so the domain bit can never drift from its message.
  logic [msg_nbits:0]   slots [p_num_entries];
  logic [ptr_nbits-1:0] head;
  logic [ptr_nbits-1:0] tail;
  logic                 accept_en;
  logic                 enq;
  logic                 deq;
  logic [msg_nbits:0]   head_slot;

  assign q.in_rdy  = accept_en & (count != cnt_full);
  assign q.out_val = (count != '0);

  assign enq = q.in_val  & q.in_rdy;
  assign deq = q.out_val & q.out_rdy;

  // accept_en holds in_rdy low through reset and releases it one edge later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      accept_en <= 1'b0;
      for (int i = 0; i < p_num_entries; i++) slots[i] <= '0;
    end else begin
      accept_en <= 1'b1;
      if (enq) begin
        slots[tail] <= {q.in_msg, q.in_ns};
        tail        <= tail + ptr_one;
      end
      if (deq) head <= head + ptr_one;
      count <= count + cnt_nbits'(enq) - cnt_nbits'(deq);
    end
  end

  assign head_slot = slots[head];
  assign q.out_ns  = head_slot[0];

  plab5_mcore_mem_req_cmsg_field_split #(
    .p_opaque_nbits (p_opaque_nbits),
    .p_addr_nbits   (p_addr_nbits),
    .p_data_nbits   (p_data_nbits),
    .p_chk_align    (p_chk_align)
  ) split (
    .msg        (head_slot[msg_nbits:1]),
    .msg_type   (q.out_type),
    .opaque     (q.out_opaque),
    .addr       (q.out_addr),
    .len        (q.out_len),
    .nbytes     (q.out_nbytes),
    .misaligned (q.out_misaligned)
  );

endmodule

// File: tb/tb_plab5_mcore_mem_req_cmsg_unpack_queue.sv
// Bench for the control-message unpack queue: a queue-based model tracks the
// expected contents and the fields are recomputed from their definitions.
module tb_plab5_mcore_mem_req_cmsg_unpack_queue;
  import plab5_mcore_mem_req_cmsg_unpack_queue_pkg::*;

  localparam int O   = 8;
  localparam int A   = 32;
  localparam int D   = 32;
  localparam int N   = 2;
  localparam int TN  = mem_req_type_nbits;
  localparam int L   = calc_len_nbits(D);
  localparam int NBW = L + 1;
  localparam int C   = TN + O + A + L;
  localparam int W   = C + 1;
  localparam int CN  = calc_cnt_nbits(N);

  typedef struct packed {
    logic [TN-1:0] typ;
    logic [O-1:0]  opq;
    logic [A-1:0]  addr;
    logic [L-1:0]  len;
    logic          ns;
  } ent_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  plab5_mcore_mem_req_cmsg_unpack_queue_if #(.p_opaque_nbits(O), .p_addr_nbits(A),
    .p_data_nbits(D)) q ();
  plab5_mcore_mem_req_cmsg_unpack_queue_if #(.p_opaque_nbits(O), .p_addr_nbits(A),
    .p_data_nbits(D)) q0 ();
  logic [CN-1:0] count;
  logic [CN-1:0] count0;

  plab5_mcore_mem_req_cmsg_unpack_queue #(.p_opaque_nbits(O), .p_addr_nbits(A),
    .p_data_nbits(D), .p_num_entries(N), .p_chk_align(1)) dut (
    .clk(clk), .reset_n(reset_n), .q(q), .count(count));

  plab5_mcore_mem_req_cmsg_unpack_queue #(.p_opaque_nbits(O), .p_addr_nbits(A),
    .p_data_nbits(D), .p_num_entries(N), .p_chk_align(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .q(q0), .count(count0));

  // ---------------- model / scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  logic [W-1:0] sent_q[$];
  bit           rdy_en_m;
  int           tests = 0;
  int           fails = 0;
  ent_t         fe[3];

  function automatic int exp_nbytes(input logic [L-1:0] len);
    return (len == 0) ? D / 8 : int'(len);
  endfunction

  function automatic bit exp_mis(input bit chk, input logic [A-1:0] addr, input int nb);
    longint unsigned ad;
    bit pow2;
    ad = 64'(addr);
    pow2 = 0;
    for (int k = 0; k <= L; k++) if (nb == (1 << k)) pow2 = 1;
    if (!chk) return 0;
    if (pow2) return (ad % longint'(nb)) != 0;
    return (ad % longint'(1 << L)) != 0;
  endfunction

  function automatic ent_t rand_ent();
    ent_t e;
    e.typ  = TN'($urandom_range(0, 2));
    e.opq  = O'($urandom);
    e.addr = A'($urandom);
    e.len  = L'($urandom_range(0, (1 << L) - 1));
    e.ns   = 1'($urandom_range(0, 1));
    return e;
  endfunction

  function automatic bit exp_rdy();
    return rdy_en_m && (exp_q.size() != N);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input ent_t e, input bit v);
    q.in_val = v;
    q.in_msg = {e.typ, e.opq, e.addr, e.len};
    q.in_ns  = e.ns;
  endtask

  task automatic drive0(input ent_t e, input bit v);
    q0.in_val = v;
    q0.in_msg = {e.typ, e.opq, e.addr, e.len};
    q0.in_ns  = e.ns;
  endtask

  // Advance one clock from a negedge to the next, updating the model with the
  // handshakes the current inputs imply.
  task automatic tick();
    bit enq, deq;
    logic [W-1:0] ent;
    enq = q.in_val && exp_rdy();
    deq = (exp_q.size() != 0) && q.out_rdy;
    ent = {q.in_msg, q.in_ns};
    @(posedge clk);
    if (deq) void'(exp_q.pop_front());
    if (enq) exp_q.push_back(ent);
    rdy_en_m = 1;
    @(negedge clk);
  endtask

  task automatic drain();
    q.in_val  = 0;
    q.out_rdy = 1;
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) tick();
    q.out_rdy = 0;
    tests++;
    if (count !== '0 || q.out_val !== 1'b0) begin
      fails++;
      $display("FAIL drain: count=%0d out_val=%b, required 0/0", count, q.out_val);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 0;
    #2;
    tests++;
    if (q.in_rdy !== 1'b0 || q.out_val !== 1'b0 || count !== '0) begin
      fails++;
      $display("FAIL reset_ctrl: in_rdy=%b out_val=%b count=%0d, required 0/0/0",
               q.in_rdy, q.out_val, count);
    end
    tests++;
    if ($isunknown({q.out_type, q.out_opaque, q.out_addr, q.out_len, q.out_nbytes,
                    q.out_ns, q.out_misaligned}) !== 1'b0) begin
      fails++;
      $display("FAIL reset_fields_x: head fields contain X, required known values");
    end
    @(negedge clk);
    reset_n  = 1;
    rdy_en_m = 0;
    tick();
    tests++;
    if (q.in_rdy !== 1'b1 || count !== '0) begin
      fails++;
      $display("FAIL reset_release: in_rdy=%b count=%0d, required 1/0", q.in_rdy, count);
    end
  endtask

  task automatic test_first();
    ent_t e;
    e = '{typ: 3'd0, opq: 8'h05, addr: 32'h1000, len: 2'd0, ns: 1'b1};
    drive(e, 1);
    tick();
    q.in_val = 0;
    tests++;
    if (q.out_val !== 1'b1 || count !== CN'(1)) begin
      fails++;
      $display("FAIL first_ctrl: out_val=%b count=%0d, required 1/1", q.out_val, count);
    end
    tests++;
    if (q.out_nbytes !== NBW'(4) || q.out_misaligned !== 1'b0 || q.out_ns !== 1'b1) begin
      fails++;
      $display("FAIL first_derived: nbytes=%0d mis=%b ns=%b, required 4/0/1",
               q.out_nbytes, q.out_misaligned, q.out_ns);
    end
    tests++;
    if ({q.out_type, q.out_opaque, q.out_addr, q.out_len} !== {e.typ, e.opq, e.addr, e.len}) begin
      fails++;
      $display("FAIL first_fields: got %h required %h",
               {q.out_type, q.out_opaque, q.out_addr, q.out_len}, {e.typ, e.opq, e.addr, e.len});
    end
    drain();
  endtask

  task automatic test_full();
    q.out_rdy = 0;
    for (int i = 0; i < 3; i++) fe[i] = rand_ent();
    drive(fe[0], 1);
    tick();
    drive(fe[1], 1);
    tick();
    tests++;
    if (q.in_rdy !== 1'b0 || count !== CN'(2)) begin
      fails++;
      $display("FAIL full_reached: in_rdy=%b count=%0d, required 0/2", q.in_rdy, count);
    end
    drive(fe[2], 1);
    tick();
    tick();
    tests++;
    if (count !== CN'(2) || q.in_rdy !== 1'b0) begin
      fails++;
      $display("FAIL full_hold: count=%0d in_rdy=%b, required 2/0", count, q.in_rdy);
    end
    tests++;
    if ({q.out_type, q.out_opaque, q.out_addr, q.out_len, q.out_ns} !== fe[0]) begin
      fails++;
      $display("FAIL full_head: got %h required %h",
               {q.out_type, q.out_opaque, q.out_addr, q.out_len, q.out_ns}, fe[0]);
    end
  endtask

  task automatic test_full_deq();
    q.out_rdy = 1;
    tick();
    tests++;
    if (count !== CN'(1) || q.in_rdy !== 1'b1) begin
      fails++;
      $display("FAIL full_deq_only: count=%0d in_rdy=%b, required 1/1", count, q.in_rdy);
    end
    tests++;
    if ({q.out_type, q.out_opaque, q.out_addr, q.out_len, q.out_ns} !== fe[1]) begin
      fails++;
      $display("FAIL full_deq_head: got %h required %h",
               {q.out_type, q.out_opaque, q.out_addr, q.out_len, q.out_ns}, fe[1]);
    end
    q.out_rdy = 0;
    tick();
    q.in_val = 0;
    tests++;
    if (count !== CN'(2)) begin
      fails++;
      $display("FAIL full_late_enq: count=%0d, required 2", count);
    end
    q.out_rdy = 1;
    tick();
    q.out_rdy = 0;
    tests++;
    if ({q.out_type, q.out_opaque, q.out_addr, q.out_len, q.out_ns} !== fe[2]) begin
      fails++;
      $display("FAIL full_late_head: got %h required %h",
               {q.out_type, q.out_opaque, q.out_addr, q.out_len, q.out_ns}, fe[2]);
    end
    drain();
  endtask

  task automatic test_stream();
    ent_t e;
    sent_q.delete();
    got_q.delete();
    q.out_rdy = 1;
    for (int i = 0; i < 12; i++) begin
      if (i < 6) begin
        e = rand_ent();
        drive(e, 1);
        sent_q.push_back(e);
        tests++;
        if (q.in_rdy !== 1'b1) begin
          fails++;
          $display("FAIL stream_rdy cycle %0d: in_rdy=%b, required 1", i, q.in_rdy);
        end
      end else begin
        q.in_val = 0;
      end
      if (q.out_val === 1'b1)
        got_q.push_back({q.out_type, q.out_opaque, q.out_addr, q.out_len, q.out_ns});
      tick();
    end
    q.out_rdy = 0;
    tests++;
    if (got_q.size() != 6) begin
      fails++;
      $display("FAIL stream_count: got %0d messages, required 6", got_q.size());
    end
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      tests++;
      if (got_q[i] !== sent_q[i]) begin
        fails++;
        $display("FAIL stream_order[%0d]: got %h required %h", i, got_q[i], sent_q[i]);
      end
    end
    drain();
  endtask

  task automatic test_misalign();
    ent_t tbl[6];
    tbl[0] = '{typ: 3'd1, opq: 8'h11, addr: 32'h1002, len: 2'd0, ns: 1'b0};
    tbl[1] = '{typ: 3'd1, opq: 8'h22, addr: 32'h1002, len: 2'd2, ns: 1'b1};
    tbl[2] = '{typ: 3'd0, opq: 8'h33, addr: 32'h1001, len: 2'd3, ns: 1'b0};
    tbl[3] = '{typ: 3'd0, opq: 8'h44, addr: 32'h1004, len: 2'd3, ns: 1'b1};
    tbl[4] = '{typ: 3'd2, opq: 8'h55, addr: 32'h1003, len: 2'd1, ns: 1'b0};
    tbl[5] = '{typ: 3'd1, opq: 8'h66, addr: 32'h1001, len: 2'd2, ns: 1'b1};
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i], 1);
      drive0(tbl[i], 1);
      tick();
      q.in_val  = 0;
      q0.in_val = 0;
      tests++;
      if (q.out_val !== 1'b1 ||
          q.out_nbytes !== NBW'(exp_nbytes(tbl[i].len)) ||
          q.out_misaligned !== exp_mis(1, tbl[i].addr, exp_nbytes(tbl[i].len))) begin
        fails++;
        $display("FAIL misalign_chk[%0d]: val=%b nbytes=%0d mis=%b, required 1/%0d/%b", i,
                 q.out_val, q.out_nbytes, q.out_misaligned, exp_nbytes(tbl[i].len),
                 exp_mis(1, tbl[i].addr, exp_nbytes(tbl[i].len)));
      end
      tests++;
      if (q0.out_val !== 1'b1 || count0 !== CN'(1) ||
          q0.out_misaligned !== exp_mis(0, tbl[i].addr, exp_nbytes(tbl[i].len))) begin
        fails++;
        $display("FAIL misalign_nochk[%0d]: val=%b count=%0d mis=%b, required 1/1/0", i,
                 q0.out_val, count0, q0.out_misaligned);
      end
      q.out_rdy  = 1;
      q0.out_rdy = 1;
      tick();
      q.out_rdy  = 0;
      q0.out_rdy = 0;
    end
    drain();
  endtask

  task automatic test_random();
    ent_t e;
    for (int i = 0; i < 300; i++) begin
      drive(rand_ent(), 1'($urandom_range(0, 1)));
      q.out_rdy = 1'($urandom_range(0, 3) != 0);
      tests++;
      if (q.in_rdy !== exp_rdy() || q.out_val !== (exp_q.size() != 0) ||
          count !== CN'(exp_q.size())) begin
        fails++;
        $display("FAIL random_ctrl cycle %0d: rdy=%b val=%b count=%0d, required %b/%b/%0d", i,
                 q.in_rdy, q.out_val, count, exp_rdy(), exp_q.size() != 0, exp_q.size());
      end
      if (exp_q.size() != 0) begin
        e = ent_t'(exp_q[0]);
        tests++;
        if ({q.out_type, q.out_opaque, q.out_addr, q.out_len, q.out_ns} !== exp_q[0] ||
            q.out_nbytes !== NBW'(exp_nbytes(e.len)) ||
            q.out_misaligned !== exp_mis(1, e.addr, exp_nbytes(e.len))) begin
          fails++;
          $display("FAIL random_head cycle %0d: got %h/%0d/%b required %h/%0d/%b", i,
                   {q.out_type, q.out_opaque, q.out_addr, q.out_len, q.out_ns}, q.out_nbytes,
                   q.out_misaligned, exp_q[0], exp_nbytes(e.len),
                   exp_mis(1, e.addr, exp_nbytes(e.len)));
        end
      end
      tick();
    end
    drain();
  endtask

  task automatic test_mid_reset();
    q.out_rdy = 0;
    drive(rand_ent(), 1);
    tick();
    drive(rand_ent(), 1);
    tick();
    tests++;
    if (count !== CN'(2)) begin
      fails++;
      $display("FAIL midrst_fill: count=%0d, required 2", count);
    end
    drive(rand_ent(), 1);
    q.out_rdy = 1;
    #2;
    reset_n = 0;
    #1;
    tests++;
    if (q.out_val !== 1'b0 || count !== '0 || q.in_rdy !== 1'b0) begin
      fails++;
      $display("FAIL midrst_async: out_val=%b count=%0d in_rdy=%b, required 0/0/0",
               q.out_val, count, q.in_rdy);
    end
    exp_q.delete();
    rdy_en_m = 0;
    @(negedge clk);
    tests++;
    if (count !== '0 || q.out_val !== 1'b0) begin
      fails++;
      $display("FAIL midrst_held: count=%0d out_val=%b, required 0/0", count, q.out_val);
    end
    reset_n   = 1;
    q.in_val  = 0;
    q.out_rdy = 0;
    tick();
    tests++;
    if (q.in_rdy !== 1'b1 || count !== '0 || q.out_val !== 1'b0) begin
      fails++;
      $display("FAIL midrst_release: in_rdy=%b count=%0d out_val=%b, required 1/0/0",
               q.in_rdy, count, q.out_val);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    reset_n    = 0;
    rdy_en_m   = 0;
    q.in_val   = 0;
    q.in_msg   = '0;
    q.in_ns    = 0;
    q.out_rdy  = 0;
    q0.in_val  = 0;
    q0.in_msg  = '0;
    q0.in_ns   = 0;
    q0.out_rdy = 0;
    test_reset();
    test_first();
    test_full();
    test_full_deq();
    test_stream();
    test_misalign();
    test_random();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
